// File: rtl/alu_issue.sv
// Two-stage issue front end for the ALU: S1 decode register, S2 writeback/branch result register.
// Optional LUI decode is enabled by defining ALU_ISSUE_LUI_EN.
`ifndef ALU_add
`define ALU_add 3'b000
`define ALU_sub 3'b001
`define ALU_and 3'b010
`define ALU_or  3'b011
`define ALU_xor 3'b100
`define ALU_slt 3'b101
`endif

module alu_issue #(
  parameter int unsigned XLEN         = 32,
  parameter logic [31:0] RESET_PC_TGT = 32'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      Alu_op,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  input  logic            zero,
  input  logic [XLEN-1:0] Alu_res,
  output logic            res_valid,
  output logic [4:0]      res_rd,
  output logic [XLEN-1:0] res_data,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic            illegal
);

  typedef enum logic [6:0] {
    OP_R   = 7'b0110011,
    OP_I   = 7'b0010011,
    OP_BR  = 7'b1100011,
    OP_LUI = 7'b0110111
  } opcode_e;

  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_b, src1, src2;
  logic            dec_legal, dec_wb, dec_br, dec_beq;
  logic [2:0]      dec_op;
  logic [XLEN-1:0] dec_a, dec_b;

  logic            valid_q, valid_d, wb_q, wb_d, br_q, br_d, beq_q, beq_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, tgt_q, tgt_d;
  logic [4:0]      rd_q, rd_d;
  logic            res_valid_q, res_valid_d, br_taken_q, br_taken_d, illegal_q, illegal_d;
  logic [4:0]      res_rd_q, res_rd_d;
  logic [XLEN-1:0] res_data_q, res_data_d, br_target_q, br_target_d;
  logic            fire, take, accept, load;

  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  // x0 reads as zero regardless of what the register file presents
  assign src1  = (in_instr[19:15] == 5'd0) ? '0 : in_rs1_val;
  assign src2  = (in_instr[24:20] == 5'd0) ? '0 : in_rs2_val;

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = `ALU_add;
    dec_a     = src1;
    dec_b     = src2;
    dec_wb    = 1'b0;
    dec_br    = 1'b0;
    dec_beq   = 1'b0;
    case (in_instr[6:0])
      OP_R: begin
        dec_wb = 1'b1;
        case (f3)
          3'b000: begin
            dec_legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            dec_op    = (f7 == 7'b0100000) ? `ALU_sub : `ALU_add;
          end
          3'b100: begin dec_legal = (f7 == 7'd0); dec_op = `ALU_xor; end
          3'b110: begin dec_legal = (f7 == 7'd0); dec_op = `ALU_or;  end
          3'b111: begin dec_legal = (f7 == 7'd0); dec_op = `ALU_and; end
          3'b010: begin dec_legal = (f7 == 7'd0); dec_op = `ALU_slt; end
          default: dec_legal = 1'b0;
        endcase
      end
      OP_I: begin
        dec_wb = 1'b1;
        dec_b  = imm_i;
        case (f3)
          3'b000: begin dec_legal = 1'b1; dec_op = `ALU_add; end
          3'b100: begin dec_legal = 1'b1; dec_op = `ALU_xor; end
          3'b110: begin dec_legal = 1'b1; dec_op = `ALU_or;  end
          3'b111: begin dec_legal = 1'b1; dec_op = `ALU_and; end
          3'b010: begin dec_legal = 1'b1; dec_op = `ALU_slt; end
          default: dec_legal = 1'b0;
        endcase
      end
      OP_BR: begin
        dec_br    = 1'b1;
        dec_op    = `ALU_sub;
        dec_beq   = (f3 == 3'b000);
        dec_legal = (f3 == 3'b000) || (f3 == 3'b001);
      end
`ifdef ALU_ISSUE_LUI_EN
      OP_LUI: begin
        dec_legal = 1'b1;
        dec_wb    = 1'b1;
        dec_a     = '0;
        dec_b     = {in_instr[31:12], 12'b0};
      end
`endif
      default: dec_legal = 1'b0;
    endcase
  end

  assign fire     = valid_q & out_ready;
  assign take     = fire & br_q & (beq_q ? zero : ~zero);
  assign in_ready = (~valid_q | out_ready) & ~br_taken_q;
  assign accept   = in_valid & in_ready;
  // a taken branch squashes whatever is accepted in its own fire cycle
  assign load     = accept & dec_legal & ~take;

  always_comb begin
    valid_d = load ? 1'b1 : (fire ? 1'b0 : valid_q);
    op_d    = load ? dec_op  : op_q;
    a_d     = load ? dec_a   : a_q;
    b_d     = load ? dec_b   : b_q;
    rd_d    = load ? in_instr[11:7] : rd_q;
    wb_d    = load ? dec_wb  : wb_q;
    br_d    = load ? dec_br  : br_q;
    beq_d   = load ? dec_beq : beq_q;
    tgt_d   = load ? in_pc + imm_b : tgt_q;

    res_valid_d = fire & wb_q & (rd_q != 5'd0);
    res_rd_d    = rd_q;
    res_data_d  = Alu_res;
    br_taken_d  = take;
    br_target_d = (fire & br_q) ? tgt_q : br_target_q;
    illegal_d   = illegal_q | (accept & ~dec_legal);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      op_q        <= `ALU_add;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      wb_q        <= 1'b0;
      br_q        <= 1'b0;
      beq_q       <= 1'b0;
      tgt_q       <= '0;
      res_valid_q <= 1'b0;
      res_rd_q    <= '0;
      res_data_q  <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= RESET_PC_TGT[XLEN-1:0];
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rd_q        <= rd_d;
      wb_q        <= wb_d;
      br_q        <= br_d;
      beq_q       <= beq_d;
      tgt_q       <= tgt_d;
      res_valid_q <= res_valid_d;
      res_rd_q    <= res_rd_d;
      res_data_q  <= res_data_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = valid_q;
  assign Alu_op    = op_q;
  assign rs1       = a_q;
  assign rs2       = b_q;
  assign res_valid = res_valid_q;
  assign res_rd    = res_rd_q;
  assign res_data  = res_data_q;
  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU attached to the issue ports.
`ifndef ALU_add
`define ALU_add 3'b000
`define ALU_sub 3'b001
`define ALU_and 3'b010
`define ALU_or  3'b011
`define ALU_xor 3'b100
`define ALU_slt 3'b101
`endif

module tb_alu_issue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, zero;
  logic [31:0] in_instr, in_pc, in_rs1_val, in_rs2_val, rs1, rs2, alu_res;
  logic [2:0]  alu_op;
  logic        res_valid, br_taken, illegal;
  logic [4:0]  res_rd;
  logic [31:0] res_data, br_target;
  int          total = 0;
  int          bad   = 0;

  alu_issue #(.XLEN(32), .RESET_PC_TGT(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .out_valid(out_valid), .out_ready(out_ready), .Alu_op(alu_op), .rs1(rs1), .rs2(rs2),
    .zero(zero), .Alu_res(alu_res), .res_valid(res_valid), .res_rd(res_rd),
    .res_data(res_data), .br_taken(br_taken), .br_target(br_target), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      `ALU_add: alu_res = rs1 + rs2;
      `ALU_sub: alu_res = rs1 - rs2;
      `ALU_and: alu_res = rs1 & rs2;
      `ALU_or:  alu_res = rs1 | rs2;
      `ALU_xor: alu_res = rs1 ^ rs2;
      `ALU_slt: alu_res = {31'b0, $signed(rs1) < $signed(rs2)};
      default:  alu_res = '0;
    endcase
    zero = (alu_res == 32'd0);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] v1, input logic [31:0] v2);
    in_valid = 1'b1; in_instr = instr; in_pc = pc; in_rs1_val = v1; in_rs2_val = v2;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_rs1_val = '0; in_rs2_val = '0;
    tick;
    total++; if ({out_valid, res_valid, br_taken, illegal} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {out_valid, res_valid, br_taken, illegal}); end
    total++; if (br_target !== 32'h0) begin bad++; $display("FAIL reset_br_target got=%h exp=00000000", br_target); end
    rst_n = 1'b1;
    tick;
    offer(32'h002081B3, 32'h0, 32'd5, 32'd7);
    tick;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL reset_preload got=%b exp=1", out_valid); end
    rst_n = 1'b0;
    #1;
    total++; if ({out_valid, alu_op, rs1, rs2} !== {1'b0, `ALU_add, 64'h0}) begin bad++; $display("FAIL reset_mid got=%b/%h/%h/%h exp=0/add/0/0", out_valid, alu_op, rs1, rs2); end
    total++; if ({res_valid, res_rd, res_data, br_taken} !== 39'h0) begin bad++; $display("FAIL reset_mid_s2 got=%b/%h/%h/%b exp=0", res_valid, res_rd, res_data, br_taken); end
    tick;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if ({res_valid, br_taken, out_valid} !== 3'b0) begin bad++; $display("FAIL reset_no_pulse cyc=%0d got=%b exp=000", i, {res_valid, br_taken, out_valid}); end
    end
  endtask

  task automatic test_add;
    out_ready = 1'b1;
    offer(32'h002081B3, 32'h0, 32'd5, 32'd7);
    tick;
    in_valid = 1'b0;
    total++; if ({out_valid, alu_op, rs1, rs2} !== {1'b1, `ALU_add, 32'd5, 32'd7}) begin bad++; $display("FAIL add_issue got=%b/%h/%h/%h exp=1/add/5/7", out_valid, alu_op, rs1, rs2); end
    tick;
    total++; if ({res_valid, res_rd, res_data} !== {1'b1, 5'd3, 32'd12}) begin bad++; $display("FAIL add_wb got=%b/%0d/%h exp=1/3/0000000c", res_valid, res_rd, res_data); end
    tick;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL add_pulse got=%b exp=0", res_valid); end
  endtask

  task automatic test_rtype_table;
    logic [31:0] instrs [5] = '{32'h40208233, 32'h0020C233, 32'h0020E233, 32'h0020F233, 32'h0020A233};
    logic [2:0]  ops    [5] = '{`ALU_sub, `ALU_xor, `ALU_or, `ALU_and, `ALU_slt};
    logic [31:0] exps   [5] = '{32'hFFFFFFFE, 32'd2, 32'd7, 32'd5, 32'd1};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(instrs[i], 32'h0, 32'd5, 32'd7);
      tick;
      in_valid = 1'b0;
      total++; if (alu_op !== ops[i]) begin bad++; $display("FAIL rtype_op idx=%0d got=%h exp=%h", i, alu_op, ops[i]); end
      tick;
      total++; if ({res_valid, res_rd, res_data} !== {1'b1, 5'd4, exps[i]}) begin bad++; $display("FAIL rtype_wb idx=%0d got=%b/%0d/%h exp=1/4/%h", i, res_valid, res_rd, res_data, exps[i]); end
    end
  endtask

  task automatic test_rd_x0;
    out_ready = 1'b1;
    offer(32'h00208033, 32'h0, 32'd5, 32'd7);
    tick;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rd0_issue got=%b exp=1", out_valid); end
    tick;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rd0_wb got=%b exp=0", res_valid); end
  endtask

  task automatic test_branch;
    out_ready = 1'b1;
    // BEQ taken, ADD behind it squashed
    offer(32'h00208463, 32'h100, 32'd4, 32'd4);
    tick;
    offer(32'h002081B3, 32'h104, 32'd5, 32'd7);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL beq_ready_fire got=%b exp=1", in_ready); end
    tick;
    in_valid = 1'b0;
    #1;
    total++; if ({br_taken, br_target} !== {1'b1, 32'h108}) begin bad++; $display("FAIL beq_taken got=%b/%h exp=1/00000108", br_taken, br_target); end
    total++; if ({in_ready, out_valid} !== 2'b00) begin bad++; $display("FAIL beq_bubble got=%b/%b exp=0/0", in_ready, out_valid); end
    tick;
    total++; if ({res_valid, br_taken} !== 2'b00) begin bad++; $display("FAIL beq_squash got=%b/%b exp=0/0", res_valid, br_taken); end
    tick;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL beq_squash2 got=%b exp=0", res_valid); end
    // BEQ not taken, ADD completes
    offer(32'h00208463, 32'h100, 32'd4, 32'd5);
    tick;
    offer(32'h002081B3, 32'h104, 32'd5, 32'd7);
    tick;
    in_valid = 1'b0;
    total++; if ({br_taken, out_valid, br_target} !== {2'b01, 32'h108}) begin bad++; $display("FAIL beq_nt got=%b/%b/%h exp=0/1/00000108", br_taken, out_valid, br_target); end
    tick;
    total++; if ({res_valid, res_rd, res_data} !== {1'b1, 5'd3, 32'd12}) begin bad++; $display("FAIL beq_nt_add got=%b/%0d/%h exp=1/3/0000000c", res_valid, res_rd, res_data); end
    // BNE taken
    offer(32'h00209463, 32'h200, 32'd4, 32'd5);
    tick;
    in_valid = 1'b0;
    tick;
    total++; if ({br_taken, br_target} !== {1'b1, 32'h208}) begin bad++; $display("FAIL bne_taken got=%b/%h exp=1/00000208", br_taken, br_target); end
    tick;
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    offer(32'h002081B3, 32'h0, 32'd5, 32'd7);
    tick;
    offer(32'hFFF00093, 32'h4, 32'd0, 32'd9);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({in_ready, res_valid, out_valid, alu_op, rs1, rs2} !== {3'b001, `ALU_add, 32'd5, 32'd7}) begin bad++; $display("FAIL stall_hold cyc=%0d got=%b/%b/%b/%h/%h/%h exp=0/0/1/add/5/7", i, in_ready, res_valid, out_valid, alu_op, rs1, rs2); end
      tick;
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%b exp=1", in_ready); end
    tick;
    in_valid = 1'b0;
    total++; if ({res_valid, res_rd, res_data} !== {1'b1, 5'd3, 32'd12}) begin bad++; $display("FAIL stall_first got=%b/%0d/%h exp=1/3/0000000c", res_valid, res_rd, res_data); end
    total++; if ({out_valid, rs1, rs2} !== {1'b1, 32'd0, 32'hFFFFFFFF}) begin bad++; $display("FAIL addi_issue got=%b/%h/%h exp=1/0/ffffffff", out_valid, rs1, rs2); end
    tick;
    total++; if ({res_valid, res_rd, res_data} !== {1'b1, 5'd1, 32'hFFFFFFFF}) begin bad++; $display("FAIL addi_wb got=%b/%0d/%h exp=1/1/ffffffff", res_valid, res_rd, res_data); end
    tick;
  endtask

  task automatic test_lui;
    out_ready = 1'b1;
    offer(32'h123452B7, 32'h0, 32'h55, 32'h66);
    tick;
    in_valid = 1'b0;
`ifdef ALU_ISSUE_LUI_EN
    total++; if ({illegal, out_valid, rs1, rs2} !== {2'b01, 32'd0, 32'h12345000}) begin bad++; $display("FAIL lui_issue got=%b/%b/%h/%h exp=0/1/0/12345000", illegal, out_valid, rs1, rs2); end
    tick;
    total++; if ({res_valid, res_rd, res_data} !== {1'b1, 5'd5, 32'h12345000}) begin bad++; $display("FAIL lui_wb got=%b/%0d/%h exp=1/5/12345000", res_valid, res_rd, res_data); end
`else
    total++; if ({illegal, out_valid} !== 2'b10) begin bad++; $display("FAIL lui_illegal got=%b/%b exp=1/0", illegal, out_valid); end
    tick;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL lui_nowb got=%b exp=0", res_valid); end
`endif
    tick;
  endtask

  task automatic test_illegal;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL ill_clear got=%b exp=0", illegal); end
    out_ready = 1'b1;
    offer(32'h00000000, 32'h0, 32'd0, 32'd0);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ill_ready got=%b exp=1", in_ready); end
    tick;
    in_valid = 1'b0;
    total++; if ({illegal, out_valid} !== 2'b10) begin bad++; $display("FAIL ill_set got=%b/%b exp=1/0", illegal, out_valid); end
    tick;
    tick;
    total++; if ({illegal, res_valid} !== 2'b10) begin bad++; $display("FAIL ill_sticky got=%b/%b exp=1/0", illegal, res_valid); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_rtype_table;
    test_rd_x0;
    test_branch;
    test_stall;
    test_lui;
    test_illegal;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Producer side of the ALU interface: decodes RV32I integer/branch instructions into Alu_op plus operand pair and registers them for the combinational ALU.
- Captures the ALU's zero/Alu_res one cycle later into a writeback/branch-resolution register, and squashes the younger instruction on a taken branch.
- Sits between fetch and the ALU/register-file writeback; two stages: S1 = decode register, S2 = result register.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- RESET_PC_TGT, 32'h0, reset value of br_target.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  S1 can accept.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction address.
- in_rs1_val  in  32  register-file value for instr[19:15].
- in_rs2_val  in  32  register-file value for instr[24:20].
- out_valid  out  1  S1 holds a decoded op.
- out_ready  in  1  ALU/writeback consumes the op this cycle.
- Alu_op  out  3  ALU operation, encoded with the `ALU_* macros from def.v.
- rs1  out  32  ALU operand A.
- rs2  out  32  ALU operand B (register or sign-extended immediate).
- zero  in  1  ALU zero flag for the op currently on Alu_op/rs1/rs2.
- Alu_res  in  32  ALU result for the op currently on Alu_op/rs1/rs2.
- res_valid  out  1  one-cycle pulse: writeback data valid.
- res_rd  out  5  destination register.
- res_data  out  32  captured Alu_res.
- br_taken  out  1  one-cycle pulse: branch resolved taken.
- br_target  out  32  branch target address.
- illegal  out  1  sticky: an undecodable instruction was offered.

Behaviour:
- Reset (async, rst_n=0):
  - S1 invalid; out_valid=0, Alu_op=`ALU_add, rs1=rs2=0.
  - res_valid=0, res_rd=0, res_data=0, br_taken=0, br_target=RESET_PC_TGT, illegal=0.
  - Reset mid-operation discards both stages; no pulse is emitted after deassertion.
- Decode map (instr[6:0], funct3, funct7):
  - R-type 0110011: ADD/SUB (f3 000, f7 0000000/0100000) -> `ALU_add/`ALU_sub; XOR 100 -> `ALU_xor; OR 110 -> `ALU_or; AND 111 -> `ALU_and; SLT 010 -> `ALU_slt. Any other f7 is illegal.
  - I-type 0010011 (f3 000/100/110/111/010 = ADDI/XORI/ORI/ANDI/SLTI): rs2 = sign-extended instr[31:20].
  - Branch 1100011: BEQ f3 000, BNE f3 001 -> `ALU_sub with register operands. br_target = in_pc + sign-extended B-immediate {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}, computed in S1 with 32-bit wrap-around.
  - rd=x0 with a writeback op: decoded normally, but res_valid stays 0.
- Illegal instruction: not loaded into S1, consumed (in_ready behaves as for a legal op), illegal set to 1 until reset.
- Handshake:
  - in_ready = (~out_valid | out_ready) & ~br_taken.
  - S1 loads on in_valid & in_ready & legal.
  - S1 outputs are held stable while out_valid & ~out_ready.
  - fire = out_valid & out_ready.
- S2 (every cycle, registered):
  - res_valid <= fire & writeback-op & rd!=0; res_data <= Alu_res; res_rd <= rd.
  - br_taken <= fire & branch & (BEQ ? zero : ~zero); br_target latched on fire of a branch.
- Latency: accepted in cycle N -> on ALU ports in N+1 -> res/br pulse in N+2 with out_ready=1. Throughput 1/cycle.
- Taken branch:
  - In the fire cycle of a taken branch, an instruction accepted that same cycle is discarded (S1 goes invalid).
  - In the following cycle (br_taken=1), in_ready=0.
  - Net penalty: exactly one squashed slot plus one bubble.
- Simultaneous fire and load: S1 is replaced by the new instruction (no bubble) unless the squash rule applies.

Optional Feature:
- Macro ALU_ISSUE_LUI_EN.
- Defined: LUI (0110111) decodes to `ALU_add with rs1=0, rs2={instr[31:12],12'b0}, normal writeback.
- Undefined: opcode 0110111 is illegal.

Test Plan:
- rst_n=0 mid-stream with out_valid=1 -> all outputs at reset values; after release, no res_valid/br_taken pulse until a new instruction is accepted.
- ADD x3,x1,x2 (0x002081B3), rs1_val=5, rs2_val=7, out_ready=1, ALU model attached -> Alu_op=`ALU_add, rs1=5, rs2=7 one cycle later; next cycle res_valid=1, res_rd=3, res_data=12.
- ADDI x1,x0,-1 (0xFFF00093) -> rs2=32'hFFFFFFFF; res_data=32'hFFFFFFFF, res_rd=1.
- BEQ x1,x2,+8 (0x00208463), pc=0x100, both values 4, followed back-to-back by ADD -> br_taken=1, br_target=0x108, the ADD never produces res_valid, in_ready=0 during the br_taken cycle; repeat with values 4/5 -> br_taken=0 and the ADD completes.
- out_ready=0 for 3 cycles with S1 full and in_valid=1 -> Alu_op/rs1/rs2 stable, in_ready=0, no res_valid; out_ready=1 -> both ops complete in order.
- in_instr=0x00000000 -> illegal=1 (sticky), out_valid stays 0; LUI x5,0x12345 (0x123452B7) -> illegal=1 without ALU_ISSUE_LUI_EN, res_data=0x12345000 with it.
